// File: rtl/seq_count_3b_bin_var_up.sv
// Programmable 3-bit up-counter: accepts a target over val/rdy, counts 0..T,
// then pulses done for one cycle; a new command can be taken in that cycle.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a command, count holds last value
//   ST_COUNT | counting up towards target, cmd_rdy low
//   ST_DONE  | one-cycle completion, count == target, ready for next cmd
module seq_count_3b_bin_var_up (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       cmd_val,
  output logic       cmd_rdy,
  input  logic [2:0] cmd_msg,
  output logic [2:0] out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [2:0] target_q, target_d;
  logic       xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 3'd0;
      target_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    cmd_rdy  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !clear;
    xfer     = cmd_val && cmd_rdy;

    if (clear) begin
      // abort wins over counting and over any pending command
      state_d = ST_IDLE;
      count_d = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (xfer) begin
            target_d = cmd_msg;
            count_d  = 3'd0;
            state_d  = (cmd_msg == 3'd0) ? ST_DONE : ST_COUNT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COUNT: begin
          // stops exactly at target, so the 3-bit increment never wraps
          count_d = count_q + 3'd1;
          if ((count_q + 3'd1) == target_q) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = 3'd0;
        end
      endcase
    end
  end

  assign out  = count_q;
  assign busy = (state_q == ST_COUNT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_count_3b_bin_var_up.sv
// Directed bench for seq_count_3b_bin_var_up; each check compares the packed
// {out, busy, done, cmd_rdy} against a hand-computed value.
module tb_seq_count_3b_bin_var_up;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       cmd_val;
  logic       cmd_rdy;
  logic [2:0] cmd_msg;
  logic [2:0] out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  seq_count_3b_bin_var_up dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .cmd_val (cmd_val),
    .cmd_rdy (cmd_rdy),
    .cmd_msg (cmd_msg),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got out/busy/done/rdy=%0d/%b/%b/%b expected %0d/%b/%b/%b",
               tag, obs[5:3], obs[2], obs[1], obs[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic exp_st(input string tag, input int o, input bit b, input bit d, input bit r);
    logic [2:0] o3;
    o3 = o[2:0];
    chk(tag, {out, busy, done, cmd_rdy}, {o3, b, d, r});
  endtask

  // advance one clock and settle clear of the edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    cmd_val = 1'b0;
    cmd_msg = 3'd0;
    cyc();
    cyc();
    exp_st("rst_state", 0, 0, 0, 1);
    reset = 1'b0;
    cyc();
    exp_st("idle_after_rst", 0, 0, 0, 1);

    // basic T=3
    cmd_val = 1'b1; cmd_msg = 3'd3;
    cyc();
    cmd_val = 1'b0;
    exp_st("t3_c0", 0, 1, 0, 0);
    cyc(); exp_st("t3_c1", 1, 1, 0, 0);
    cyc(); exp_st("t3_c2", 2, 1, 0, 0);
    cyc(); exp_st("t3_done", 3, 0, 1, 1);
    cyc(); exp_st("t3_idle", 3, 0, 0, 1);

    // T=0 boundary
    cmd_val = 1'b1; cmd_msg = 3'd0;
    cyc();
    cmd_val = 1'b0;
    exp_st("t0_done", 0, 0, 1, 1);
    cyc(); exp_st("t0_idle", 0, 0, 0, 1);

    // T=7 boundary, no wrap
    cmd_val = 1'b1; cmd_msg = 3'd7;
    cyc();
    cmd_val = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_st("t7_count", i, 1, 0, 0);
      cyc();
    end
    exp_st("t7_done", 7, 0, 1, 1);
    cyc(); exp_st("t7_idle", 7, 0, 0, 1);
    cyc(); exp_st("t7_hold", 7, 0, 0, 1);

    // back-to-back T=2, T=0, T=1 with cmd_val held high
    cmd_val = 1'b1; cmd_msg = 3'd2;
    cyc(); exp_st("b2b_a0", 0, 1, 0, 0);
    cyc(); exp_st("b2b_a1", 1, 1, 0, 0);
    cyc(); exp_st("b2b_a_done", 2, 0, 1, 1);
    cmd_msg = 3'd0;
    cyc(); exp_st("b2b_b_done", 0, 0, 1, 1);
    cmd_msg = 3'd1;
    cyc(); exp_st("b2b_c0", 0, 1, 0, 0);
    cmd_val = 1'b0;
    cyc(); exp_st("b2b_c_done", 1, 0, 1, 1);
    cyc(); exp_st("b2b_idle", 1, 0, 0, 1);

    // backpressure: T=6 offered while T=4 counts
    cmd_val = 1'b1; cmd_msg = 3'd4;
    cyc();
    cmd_msg = 3'd6;
    exp_st("bp_a0", 0, 1, 0, 0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      exp_st("bp_a_count", i, 1, 0, 0);
    end
    cyc(); exp_st("bp_a_done", 4, 0, 1, 1);
    cyc(); exp_st("bp_b0", 0, 1, 0, 0);
    cmd_val = 1'b0;
    for (int i = 1; i < 6; i++) begin
      cyc();
      exp_st("bp_b_count", i, 1, 0, 0);
    end
    cyc(); exp_st("bp_b_done", 6, 0, 1, 1);
    cyc(); exp_st("bp_idle", 6, 0, 0, 1);

    // clear together with a command in DONE
    cmd_val = 1'b1; cmd_msg = 3'd1;
    cyc(); exp_st("clr_a0", 0, 1, 0, 0);
    cyc(); exp_st("clr_a_done", 1, 0, 1, 1);
    clear = 1'b1; cmd_msg = 3'd5;
    #1 exp_st("clr_rdy_low", 1, 0, 1, 0);
    cyc();
    clear = 1'b0; cmd_val = 1'b0;
    #1 exp_st("clr_no_xfer", 0, 0, 0, 1);
    cyc(); exp_st("clr_idle", 0, 0, 0, 1);

    // clear mid-count
    cmd_val = 1'b1; cmd_msg = 3'd6;
    cyc();
    cmd_val = 1'b0;
    cyc(); cyc(); cyc();
    exp_st("clrmid_at3", 3, 1, 0, 0);
    clear = 1'b1;
    cyc(); exp_st("clrmid_abort", 0, 0, 0, 0);
    clear = 1'b0;
    #1 exp_st("clrmid_idle", 0, 0, 0, 1);
    cyc(); exp_st("clrmid_no_done", 0, 0, 0, 1);

    // async reset mid-count
    cmd_val = 1'b1; cmd_msg = 3'd5;
    cyc();
    cmd_val = 1'b0;
    cyc(); cyc();
    exp_st("rstmid_at2", 2, 1, 0, 0);
    reset = 1'b1;
    #1 exp_st("rstmid_immediate", 0, 0, 0, 1);
    cyc(); exp_st("rstmid_held", 0, 0, 0, 1);
    reset = 1'b0;
    cmd_val = 1'b1; cmd_msg = 3'd1;
    cyc(); exp_st("rstmid_t1_c0", 0, 1, 0, 0);
    cmd_val = 1'b0;
    cyc(); exp_st("rstmid_t1_done", 1, 0, 1, 1);
    cyc(); exp_st("rstmid_t1_idle", 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_count_3b_bin_var_up.md
# seq_count_3b_bin_var_up

Programmable 3-bit binary up-counter that takes a target value through a val/rdy command interface, counts from 0 up to that target, and signals completion with a one-cycle `done` pulse. It is the counting-up counterpart to the team's variable-length down-counter. It sits beside control FSMs that issue a length and wait for completion. Back-to-back commands are accepted in the completion cycle, so a stream of lengths runs with no idle gap.

## Interface
- No parameters; all widths are fixed at 3 bits.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `clear`  in  1  — synchronous abort; returns the block to IDLE.
- `cmd_val`  in  1  — command valid.
- `cmd_rdy`  out  1  — command ready; a transfer occurs when `cmd_val & cmd_rdy` is high at a rising edge.
- `cmd_msg`  in  3  — target count T (0–7).
- `out`  out  3  — current count value.
- `busy`  out  1  — high while in COUNT.
- `done`  out  1  — one-cycle pulse in the cycle where `out == T`.

## Operation
- **State machine:** IDLE, COUNT, DONE. Registers: `state`, `count[2:0]`, `target[2:0]`.
- **Outputs:**
  - `out = count`
  - `busy = (state == COUNT)`
  - `done = (state == DONE)`
  - `cmd_rdy = (state == IDLE || state == DONE) && !clear`, which is combinational from state and `clear` only.
- **Accept:** on a transfer, `target <= cmd_msg` and `count <= 0`.
  - If `cmd_msg == 0`, next state is DONE.
  - Otherwise, next state is COUNT.
- **IDLE:** `count` holds its last value. It is 0 after reset or `clear`, otherwise the last target reached. Without a transfer, the block stays in IDLE.
- **COUNT:** `count <= count + 1` each cycle.
  - When `count + 1 == target`, next state is DONE.
  - `cmd_val` is ignored here because `cmd_rdy` is 0.
- **DONE:** lasts exactly one cycle, with `count == target`.
  - With a transfer, apply the accept rules, so a new count starts at 0.
  - Without a transfer, next state is IDLE and `count` holds at the target.
- **Arithmetic:** `count` never exceeds `target` and never wraps. T=7 counts 0..7 and stops. No 3-bit overflow path is reachable.
- **`clear`** (synchronous, any state): next state is IDLE and `count <= 0`. `clear` has priority over counting and over any transfer, and no transfer occurs in that cycle.
- **`reset`** (asynchronous, any state, including mid-count): `state = IDLE`, `count = 0`, `target = 0` immediately.
  - Output values during and after reset: `out = 0`, `busy = 0`, `done = 0`, `cmd_rdy = 1` (if `clear` is low).
  - Release from reset is synchronous to the next edge with no extra latency.

## Timing
- Transfer at edge e with target T:
  - T ≥ 1: `out` = 0 in the cycle after e, incrementing by 1 per cycle. `done` is high and `out` = T in cycle e+T+1 (T+1 cycles after e). `busy` is high for exactly T cycles.
  - T = 0: `done` = 1 and `out` = 0 in the cycle right after e. `busy` never rises.
- Throughput: a transfer in the DONE cycle gives zero idle cycles between jobs. Each job occupies T+1 cycles.
- `cmd_rdy` is low for all COUNT cycles. Upstream must hold `cmd_val` and `cmd_msg` stable until the transfer.
- `done` is never high for two consecutive cycles unless the new job has T = 0 (DONE → DONE back-to-back).

## Test plan
- **Reset mid-count:** load T=5, assert `reset` when `out` = 2 → `out` = 0, `busy` = 0, `done` = 0, `cmd_rdy` = 1 immediately. The next command T=1 completes normally.
- **Basic count:** T=3 accepted at edge e → `out` sequence 0, 1, 2, 3, with `busy` = 1,1,1,0 and `done` = 0,0,0,1. The following cycle is IDLE with `out` = 3.
- **Boundaries:** T=0 gives `done` at e+1 with `out` = 0. T=7 gives `out` 0..7 with `done` at e+8 and no wrap to 0.
- **Back-to-back:** hold `cmd_val` high with T=2 then T=0 then T=1 → `done` in cycles e+3, e+4, e+6, with `out` sequence 0,1,2,0,0,1.
- **Backpressure:** drive `cmd_val` with T=6 while counting T=4 → `cmd_rdy` stays 0 until DONE. The new job starts without loss, and T=6 completes 7 cycles later.
- **Clear vs. command:** assert `clear` together with `cmd_val` in DONE → no transfer, `out` = 0, IDLE. Assert `clear` mid-count at `out` = 3 → `out` = 0 next cycle with no `done` pulse.
